exe_hazard_ctrl: RTL and testbench
==================================

Name: exe_hazard_ctrl

Overview:
- Controller for the single-issue EXE stage. It detects load-use hazards, generates registered forwarding selects for ALU operands A/B (MEM-stage or WB-stage data), and sequences the multicycle MULT/DIV unit that writes HI/LO.
- Sits beside the ID/EXE pipeline register.
- Its stall and bubble outputs freeze IF/ID and inject a NOP into EXE.

Parameters:
- MUL_LAT, 4, cycles a MULT/MULTU occupies the MDU (>=1)
- DIV_LAT, 32, cycles a DIV/DIVU occupies the MDU (>=MUL_LAT)
- CNT_W, $clog2(DIV_LAT), MDU countdown width

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous active-low reset
- valid_ID  in  1  ID holds a real instruction
- flush  in  1  branch redirect; kills the ID instruction
- ALU_control_ID  in  6  ID-stage ALU op
- readRegisterA_ID  in  5  rs of ID instruction
- readRegisterB_ID  in  5  rt of ID instruction
- writeRegister_EX  in  5  destination of EXE instruction
- do_writeback_EX  in  1  EXE instruction writes a register
- MemRead_EX  in  1  EXE instruction is a load
- writeRegister_MEM  in  5  destination of MEM instruction
- do_writeback_MEM  in  1  MEM instruction writes a register
- fwdA_sel  out  2  00 regfile, 01 Data_MEM, 10 Data_WB (registered)
- fwdB_sel  out  2  same encoding for operand B (registered)
- stall  out  1  hold PC and IF/ID (combinational)
- bubble  out  1  load NOP into ID/EXE (combinational, = stall | flush)
- mdu_start  out  1  one-cycle start pulse to MDU (registered)
- mdu_busy  out  1  MDU occupied
- hilo_we  out  1  HI/LO write strobe, one cycle
- stall_cycles  out  32  saturating count of stalled cycles

Behaviour:
- Reset (async, RESET=0): fwdA_sel=fwdB_sel=00, mdu_start=0, state=IDLE, cnt=0, stall_cycles=0. The combinational outputs stall, bubble, hilo_we and mdu_busy then evaluate to 0 unless flush=1.
- Issue condition: issue = valid_ID & ~flush & ~stall.
- Load-use hazard: lu = valid_ID & MemRead_EX & do_writeback_EX & (writeRegister_EX!=0) & (writeRegister_EX==readRegisterA_ID | writeRegister_EX==readRegisterB_ID). lu lasts exactly one cycle, because the bubble removes the load from EXE.
- MDU hazard: md = valid_ID & (state!=IDLE) & (ALU_control_ID in {MULT,MULTU,DIV,DIVU,MFHI,MFLO}).
- stall = (lu | md) & ~flush. Flush wins; the killed instruction never stalls.
- Forward selects are updated on each edge where issue=1, computed per operand X in {A,B}:
  - if do_writeback_EX & writeRegister_EX!=0 & writeRegister_EX==readRegisterX_ID, then 01 (the producer will be in MEM);
  - else if do_writeback_MEM & writeRegister_MEM!=0 & match, then 10;
  - else 00.
  - EX match has priority over MEM match.
- On an edge with bubble=1, both selects load 00. Otherwise they hold.
- FSM states: IDLE, BUSY.
  - IDLE -> BUSY when issue & op in {MULT,MULTU,DIV,DIVU}. At that edge: cnt <= (MUL_LAT or DIV_LAT)-1, mdu_start <= 1.
  - mdu_start clears on the next edge.
  - In BUSY: cnt decrements each cycle. When cnt==0, hilo_we=1 and the next edge returns to IDLE.
  - mdu_busy = (state==BUSY). Busy duration is exactly LAT cycles.
- Simultaneous events:
  - MFHI/MFLO or MULT/DIV in ID during the hilo_we cycle is still stalled. It issues the following cycle, so a back-to-back MULT restarts on that edge.
  - Non-MDU instructions issue freely while BUSY.
  - flush does not abort an in-flight MDU op.
- Reset mid-operation: FSM returns to IDLE with no hilo_we.
- stall_cycles increments on each edge with stall=1 and saturates at 32'hFFFF_FFFF.

Decomposition:
- Shared package exe_pkg: ALU op codes MULT=6'h18, MULTU=6'h19, DIV=6'h1A, DIVU=6'h1B, MFHI=6'h10, MFLO=6'h12; FWD_REG/FWD_MEM/FWD_WB encodings; FSM state typedef.
- One sub-module is natural: mdu_sequencer, containing the FSM, countdown, mdu_start, hilo_we and mdu_busy. Hazard and forwarding logic stays in the top.

Test Plan:
- Load-use: lw r5 in EX, add r7,r5,r6 in ID. Required: stall=bubble=1 for exactly one cycle, stall_cycles=1. After the add issues, fwdA_sel=10 and fwdB_sel=00.
- EX forward: add r3 in EX (do_writeback=1), sub r4,r1,r3 in ID. Required: after the edge, fwdB_sel=01 and fwdA_sel=00, with no stall. Same hazard with r3 also in MEM gives 01 (EX priority).
- r0 guard: EX and MEM both write r0, ID reads r0/r0. Required: selects stay 00, stall=0, even if MemRead_EX=1.
- MULT, MUL_LAT=4: mdu_start high one cycle after issue, mdu_busy high 4 cycles, hilo_we in the 4th. MFHI in ID during that span stalls 4 cycles and issues the cycle after hilo_we.
- Reset mid-DIV: RESET low at busy cycle 10. Required: all outputs 0 immediately with no hilo_we. After release, a new DIV takes a full 32 busy cycles.
- Flush during load-use: flush=1 with lu conditions true. Required: stall=0, bubble=1, selects 00, stall_cycles unchanged.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared definitions for the EXE-stage hazard controller: ALU op codes,
// forwarding-select encodings, MDU sequencer state and small decode helpers.
// Latency: n/a (constants and pure functions). Backpressure: n/a.
package exe_pkg;

  // ALU op codes that interact with the multicycle MULT/DIV unit.
  localparam logic [5:0] MULT  = 6'h18;
  localparam logic [5:0] MULTU = 6'h19;
  localparam logic [5:0] DIV   = 6'h1A;
  localparam logic [5:0] DIVU  = 6'h1B;
  localparam logic [5:0] MFHI  = 6'h10;
  localparam logic [5:0] MFLO  = 6'h12;

  // Operand forwarding selects.
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // MDU sequencer state.
  typedef logic [0:0] mdu_state_t;
  localparam mdu_state_t ST_IDLE = 1'b0;
  localparam mdu_state_t ST_BUSY = 1'b1;

  // Ops that launch a new MDU operation.
  function automatic logic is_mdu_launch(input logic [5:0] op);
    return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
  endfunction

  // Launch ops that take the long (divide) latency.
  function automatic logic is_div_op(input logic [5:0] op);
    return (op == DIV) || (op == DIVU);
  endfunction

  // Ops that must wait for HI/LO to settle: new launches and HI/LO reads.
  function automatic logic is_hilo_user(input logic [5:0] op);
    return is_mdu_launch(op) || (op == MFHI) || (op == MFLO);
  endfunction

  // Forward select for one source register. The EXE producer is newer than
  // the MEM producer, so it wins; r0 is never forwarded.
  function automatic logic [1:0] fwd_pick(
    input logic [4:0] src,
    input logic [4:0] wr_ex,
    input logic       wb_ex,
    input logic [4:0] wr_mem,
    input logic       wb_mem
  );
    if (wb_ex && (wr_ex != 5'd0) && (wr_ex == src))
      return FWD_MEM;
    else if (wb_mem && (wr_mem != 5'd0) && (wr_mem == src))
      return FWD_WB;
    else
      return FWD_REG;
  endfunction

endpackage

// File: rtl/mdu_sequencer.sv
// Sequences the multicycle MULT/DIV unit: start pulse, busy window, HI/LO write strobe.
// Latency: mdu_start one cycle after launch edge; busy exactly LAT cycles, hilo_we in the last.
// Backpressure: none; caller must only assert launch when idle (top stalls HI/LO users while busy).
//
// Ports:
//   CLK, RESET     clock, async active-low reset
//   launch         issue of a MULT/MULTU/DIV/DIVU this cycle
//   launch_div     launched op is a divide (selects DIV_LAT)
//   mdu_start      registered one-cycle start pulse to the MDU
//   mdu_busy       MDU occupied
//   hilo_we        HI/LO write strobe, final busy cycle
module mdu_sequencer
  import exe_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = ($clog2(DIV_LAT) > 0) ? $clog2(DIV_LAT) : 1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic launch,
  input  logic launch_div,
  output logic mdu_start,
  output logic mdu_busy,
  output logic hilo_we
);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  mdu_state_t       state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      mdu_start <= 1'b0;
    end else begin
      mdu_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (launch) begin
            state     <= ST_BUSY;
            // Loaded with LAT-1 so the countdown reaching zero marks the LAT-th busy cycle.
            cnt       <= launch_div ? DIV_CNT : MUL_CNT;
            mdu_start <= 1'b1;
          end
        end
        default: begin
          if (cnt == '0)
            state <= ST_IDLE;
          else
            cnt <= cnt - 1'b1;
        end
      endcase
    end
  end

  assign mdu_busy = (state == ST_BUSY);
  assign hilo_we  = (state == ST_BUSY) && (cnt == '0);

endmodule

// File: rtl/exe_hazard_ctrl.sv
// EXE-stage controller: load-use / MDU hazard stalls, registered ALU operand forward selects, MDU sequencing.
// Latency: stall/bubble combinational; forward selects and mdu_start registered (valid the cycle after issue).
// Backpressure: stall freezes PC and IF/ID, bubble injects a NOP into ID/EXE; flush overrides stall.
//
// Ports:
//   CLK, RESET                          clock, async active-low reset
//   valid_ID, flush, ALU_control_ID     ID instruction state and redirect kill
//   readRegisterA_ID/B_ID               ID source registers
//   writeRegister_EX, do_writeback_EX,
//   MemRead_EX                          EXE-stage producer
//   writeRegister_MEM, do_writeback_MEM MEM-stage producer
//   fwdA_sel, fwdB_sel                  00 regfile, 01 MEM data, 10 WB data
//   stall, bubble                       pipeline hold / NOP injection
//   mdu_start, mdu_busy, hilo_we        MDU control
//   stall_cycles                        saturating count of stalled cycles
module exe_hazard_ctrl
  import exe_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = ($clog2(DIV_LAT) > 0) ? $clog2(DIV_LAT) : 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        valid_ID,
  input  logic        flush,
  input  logic [5:0]  ALU_control_ID,
  input  logic [4:0]  readRegisterA_ID,
  input  logic [4:0]  readRegisterB_ID,
  input  logic [4:0]  writeRegister_EX,
  input  logic        do_writeback_EX,
  input  logic        MemRead_EX,
  input  logic [4:0]  writeRegister_MEM,
  input  logic        do_writeback_MEM,
  output logic [1:0]  fwdA_sel,
  output logic [1:0]  fwdB_sel,
  output logic        stall,
  output logic        bubble,
  output logic        mdu_start,
  output logic        mdu_busy,
  output logic        hilo_we,
  output logic [31:0] stall_cycles
);

  logic lu_hazard;
  logic md_hazard;
  logic issue;
  logic launch;

  // A load in EXE cannot forward in time for the next instruction; one bubble
  // moves it to MEM, after which the WB path covers it.
  assign lu_hazard = valid_ID && MemRead_EX && do_writeback_EX &&
                     (writeRegister_EX != 5'd0) &&
                     ((writeRegister_EX == readRegisterA_ID) ||
                      (writeRegister_EX == readRegisterB_ID));

  // HI/LO users wait until the sequencer is idle again, including through the
  // hilo_we cycle, so a back-to-back launch starts on the following edge.
  assign md_hazard = valid_ID && mdu_busy && is_hilo_user(ALU_control_ID);

  assign stall  = (lu_hazard || md_hazard) && !flush;
  assign bubble = stall || flush;
  assign issue  = valid_ID && !flush && !stall;
  assign launch = issue && is_mdu_launch(ALU_control_ID);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      fwdA_sel <= FWD_REG;
      fwdB_sel <= FWD_REG;
    end else if (bubble) begin
      fwdA_sel <= FWD_REG;
      fwdB_sel <= FWD_REG;
    end else if (issue) begin
      fwdA_sel <= fwd_pick(readRegisterA_ID, writeRegister_EX, do_writeback_EX,
                           writeRegister_MEM, do_writeback_MEM);
      fwdB_sel <= fwd_pick(readRegisterB_ID, writeRegister_EX, do_writeback_EX,
                           writeRegister_MEM, do_writeback_MEM);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      stall_cycles <= '0;
    else if (stall && (stall_cycles != 32'hFFFF_FFFF))
      stall_cycles <= stall_cycles + 32'd1;
  end

  mdu_sequencer #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) u_mdu_sequencer (
    .CLK        (CLK),
    .RESET      (RESET),
    .launch     (launch),
    .launch_div (is_div_op(ALU_control_ID)),
    .mdu_start  (mdu_start),
    .mdu_busy   (mdu_busy),
    .hilo_we    (hilo_we)
  );

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Directed and random checks of exe_hazard_ctrl against a cycle-level reference model.
// Latency: n/a. Backpressure: n/a.
module tb_exe_hazard_ctrl;
  import exe_pkg::*;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        valid_ID = 1'b0;
  logic        flush = 1'b0;
  logic [5:0]  ALU_control_ID = '0;
  logic [4:0]  readRegisterA_ID = '0;
  logic [4:0]  readRegisterB_ID = '0;
  logic [4:0]  writeRegister_EX = '0;
  logic        do_writeback_EX = 1'b0;
  logic        MemRead_EX = 1'b0;
  logic [4:0]  writeRegister_MEM = '0;
  logic        do_writeback_MEM = 1'b0;
  logic [1:0]  fwdA_sel, fwdB_sel;
  logic        stall, bubble, mdu_start, mdu_busy, hilo_we;
  logic [31:0] stall_cycles;

  always #5 CLK = ~CLK;

  exe_hazard_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .CLK(CLK), .RESET(RESET), .valid_ID(valid_ID), .flush(flush),
    .ALU_control_ID(ALU_control_ID),
    .readRegisterA_ID(readRegisterA_ID), .readRegisterB_ID(readRegisterB_ID),
    .writeRegister_EX(writeRegister_EX), .do_writeback_EX(do_writeback_EX),
    .MemRead_EX(MemRead_EX),
    .writeRegister_MEM(writeRegister_MEM), .do_writeback_MEM(do_writeback_MEM),
    .fwdA_sel(fwdA_sel), .fwdB_sel(fwdB_sel), .stall(stall), .bubble(bubble),
    .mdu_start(mdu_start), .mdu_busy(mdu_busy), .hilo_we(hilo_we),
    .stall_cycles(stall_cycles)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: remaining busy cycles of the MDU (0 = idle), forward
  // selects, pending start pulse and stall count.
  int         m_rem;
  logic [1:0] m_fa, m_fb;
  logic       m_start;
  longint     m_sc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rem = 0; m_fa = 2'b00; m_fb = 2'b00; m_start = 1'b0; m_sc = 0;
  endtask

  function automatic logic [1:0] ref_sel(input logic [4:0] r);
    if (do_writeback_EX && writeRegister_EX != 5'd0 && writeRegister_EX == r) return 2'b01;
    if (do_writeback_MEM && writeRegister_MEM != 5'd0 && writeRegister_MEM == r) return 2'b10;
    return 2'b00;
  endfunction

  task automatic set_id(input logic v, input logic [5:0] op, input logic [4:0] ra, input logic [4:0] rb);
    valid_ID = v; ALU_control_ID = op; readRegisterA_ID = ra; readRegisterB_ID = rb;
  endtask

  task automatic set_ex(input logic [4:0] wr, input logic wb, input logic mr);
    writeRegister_EX = wr; do_writeback_EX = wb; MemRead_EX = mr;
  endtask

  task automatic set_mem(input logic [4:0] wr, input logic wb);
    writeRegister_MEM = wr; do_writeback_MEM = wb;
  endtask

  // Check every output against the model on the falling edge, then advance the
  // model across the next rising edge. Returns at rising edge + 1.
  task automatic run_cycle();
    logic lu, md, st, bub, iss, mop;
    int nrem;
    logic [1:0] nfa, nfb;
    logic nstart;
    longint nsc;
    @(negedge CLK);
    mop = (ALU_control_ID == MULT) || (ALU_control_ID == MULTU) ||
          (ALU_control_ID == DIV)  || (ALU_control_ID == DIVU);
    lu  = valid_ID && MemRead_EX && do_writeback_EX && writeRegister_EX != 5'd0 &&
          (writeRegister_EX == readRegisterA_ID || writeRegister_EX == readRegisterB_ID);
    md  = valid_ID && (m_rem > 0) && (mop || ALU_control_ID == MFHI || ALU_control_ID == MFLO);
    st  = (lu || md) && !flush;
    bub = st || flush;
    iss = valid_ID && !flush && !st;
    chk("stall", {31'd0, stall}, {31'd0, st});
    chk("bubble", {31'd0, bubble}, {31'd0, bub});
    chk("mdu_busy", {31'd0, mdu_busy}, {31'd0, (m_rem > 0)});
    chk("hilo_we", {31'd0, hilo_we}, {31'd0, (m_rem == 1)});
    chk("mdu_start", {31'd0, mdu_start}, {31'd0, m_start});
    chk("fwdA_sel", {30'd0, fwdA_sel}, {30'd0, m_fa});
    chk("fwdB_sel", {30'd0, fwdB_sel}, {30'd0, m_fb});
    chk("stall_cycles", stall_cycles, m_sc[31:0]);
    nfa = bub ? 2'b00 : (iss ? ref_sel(readRegisterA_ID) : m_fa);
    nfb = bub ? 2'b00 : (iss ? ref_sel(readRegisterB_ID) : m_fb);
    if (m_rem > 0) nrem = m_rem - 1;
    else if (iss && mop) nrem = (ALU_control_ID == DIV || ALU_control_ID == DIVU) ? DIV_LAT : MUL_LAT;
    else nrem = 0;
    nstart = (m_rem == 0) && iss && mop;
    nsc = (st && m_sc != 64'h0000_0000_FFFF_FFFF) ? m_sc + 1 : m_sc;
    @(posedge CLK);
    #1;
    m_rem = nrem; m_fa = nfa; m_fb = nfb; m_start = nstart; m_sc = nsc;
  endtask

  initial begin
    int busy_n, hilo_n, sel;
    logic [5:0] ops [0:3];
    ops[0] = MULT; ops[1] = DIVU; ops[2] = MFHI; ops[3] = MFLO;

    // Reset state
    model_reset();
    #2;
    chk("rst_fwdA", {30'd0, fwdA_sel}, 32'd0);
    chk("rst_fwdB", {30'd0, fwdB_sel}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_bubble", {31'd0, bubble}, 32'd0);
    chk("rst_start", {31'd0, mdu_start}, 32'd0);
    chk("rst_busy", {31'd0, mdu_busy}, 32'd0);
    chk("rst_hilo", {31'd0, hilo_we}, 32'd0);
    chk("rst_sc", stall_cycles, 32'd0);
    #10 RESET = 1'b1;
    @(posedge CLK); #1;

    // Load-use: lw r5 in EX, add r7,r5,r6 in ID
    set_ex(5'd5, 1'b1, 1'b1); set_mem(5'd0, 1'b0); set_id(1'b1, 6'h20, 5'd5, 5'd6);
    #1;
    chk("lu_stall", {31'd0, stall}, 32'd1);
    chk("lu_bubble", {31'd0, bubble}, 32'd1);
    run_cycle();
    set_ex(5'd0, 1'b0, 1'b0); set_mem(5'd5, 1'b1);
    #1;
    chk("lu_stall_gone", {31'd0, stall}, 32'd0);
    chk("lu_sc", stall_cycles, 32'd1);
    run_cycle();
    chk("lu_fwdA", {30'd0, fwdA_sel}, 32'd2);
    chk("lu_fwdB", {30'd0, fwdB_sel}, 32'd0);

    // EX forward, then EX priority over MEM
    set_ex(5'd3, 1'b1, 1'b0); set_mem(5'd0, 1'b0); set_id(1'b1, 6'h22, 5'd1, 5'd3);
    #1;
    chk("exf_stall", {31'd0, stall}, 32'd0);
    run_cycle();
    chk("exf_fwdB", {30'd0, fwdB_sel}, 32'd1);
    chk("exf_fwdA", {30'd0, fwdA_sel}, 32'd0);
    set_mem(5'd3, 1'b1);
    run_cycle();
    chk("prio_fwdB", {30'd0, fwdB_sel}, 32'd1);

    // r0 guard
    set_ex(5'd0, 1'b1, 1'b1); set_mem(5'd0, 1'b1); set_id(1'b1, 6'h20, 5'd0, 5'd0);
    #1;
    chk("r0_stall", {31'd0, stall}, 32'd0);
    run_cycle();
    chk("r0_fwdA", {30'd0, fwdA_sel}, 32'd0);
    chk("r0_fwdB", {30'd0, fwdB_sel}, 32'd0);

    // Flush during load-use (selects made non-zero first)
    set_ex(5'd5, 1'b1, 1'b0); set_mem(5'd0, 1'b0); set_id(1'b1, 6'h20, 5'd5, 5'd5);
    run_cycle();
    set_ex(5'd5, 1'b1, 1'b1); flush = 1'b1;
    #1;
    chk("fl_stall", {31'd0, stall}, 32'd0);
    chk("fl_bubble", {31'd0, bubble}, 32'd1);
    run_cycle();
    chk("fl_fwdA", {30'd0, fwdA_sel}, 32'd0);
    chk("fl_fwdB", {30'd0, fwdB_sel}, 32'd0);
    chk("fl_sc", stall_cycles, 32'd1);
    flush = 1'b0;

    // MULT followed by MFHI
    set_ex(5'd0, 1'b0, 1'b0); set_mem(5'd0, 1'b0); set_id(1'b1, MULT, 5'd1, 5'd2);
    run_cycle();
    set_id(1'b1, MFHI, 5'd0, 5'd0);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("mul_busy", {31'd0, mdu_busy}, 32'd1);
      chk("mul_stall", {31'd0, stall}, 32'd1);
      chk("mul_hilo", {31'd0, hilo_we}, (i == 3) ? 32'd1 : 32'd0);
      chk("mul_start", {31'd0, mdu_start}, (i == 0) ? 32'd1 : 32'd0);
      run_cycle();
    end
    chk("mul_idle", {31'd0, mdu_busy}, 32'd0);
    chk("mfhi_issue", {31'd0, stall}, 32'd0);
    run_cycle();

    // Reset in busy cycle 10 of a DIV
    set_id(1'b1, DIV, 5'd1, 5'd2);
    run_cycle();
    set_id(1'b0, 6'h20, 5'd0, 5'd0);
    for (int i = 0; i < 9; i++) run_cycle();
    RESET = 1'b0;
    #1;
    model_reset();
    chk("mrst_busy", {31'd0, mdu_busy}, 32'd0);
    chk("mrst_hilo", {31'd0, hilo_we}, 32'd0);
    chk("mrst_start", {31'd0, mdu_start}, 32'd0);
    chk("mrst_stall", {31'd0, stall}, 32'd0);
    chk("mrst_sc", stall_cycles, 32'd0);
    #1 RESET = 1'b1;
    set_id(1'b1, DIV, 5'd1, 5'd2);
    run_cycle();
    set_id(1'b0, 6'h20, 5'd0, 5'd0);
    busy_n = 0; hilo_n = 0;
    for (int i = 0; i < 100; i++) begin
      if (!mdu_busy) break;
      busy_n++;
      if (hilo_we) hilo_n++;
      run_cycle();
    end
    chk("div_busy_len", busy_n, DIV_LAT);
    chk("div_hilo_cnt", hilo_n, 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      sel = $urandom_range(0, 15);
      set_id(($urandom_range(0, 7) != 0),
             (sel < 4) ? ops[sel] : 6'(6'h20 + $urandom_range(0, 7)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      set_ex(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      set_mem(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      flush = ($urandom_range(0, 9) == 0);
      run_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
